// File: rtl/alu_sequencer.sv
// alu_sequencer: T0-T5 fetch/decode/execute control for the basic computer.
// Decodes IR, handshakes with memory and drives ALU op and AC/E load strobes.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mem_ack,
    input  logic [15:0] ir_outdata,
    output logic [3:0]  alu_code,
    output logic        ar_load,
    output logic        ar_src_pc,
    output logic        mem_read,
    output logic        ir_load,
    output logic        dr_load,
    output logic        pc_inc,
    output logic        ac_load,
    output logic        e_load,
    output logic        fgi_clear,
    output logic [2:0]  sc_outdata,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_i;
    logic [2:0] r_op;
    logic       w_memref;
    logic       w_unused;

    assign w_memref = (r_op == 3'b000) || (r_op == 3'b001)
                   || (r_op == 3'b010);
    assign w_unused = ^{ir_outdata[10], ir_outdata[5:1]};

    // Strobe decode and next-state selection from the registered state.
    always_comb begin
        w_next     = r_state;
        alu_code   = 4'b0000;
        ar_load    = 1'b0;
        ar_src_pc  = 1'b0;
        mem_read   = 1'b0;
        ir_load    = 1'b0;
        dr_load    = 1'b0;
        pc_inc     = 1'b0;
        ac_load    = 1'b0;
        e_load     = 1'b0;
        fgi_clear  = 1'b0;
        sc_outdata = 3'd7;
        halted     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_T0;
            end
            S_T0: begin
                sc_outdata = 3'd0;
                ar_load    = 1'b1;
                ar_src_pc  = 1'b1;
                w_next     = S_T1;
            end
            S_T1: begin
                sc_outdata = 3'd1;
                mem_read   = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = S_T2;
                end
            end
            S_T2: begin
                sc_outdata = 3'd2;
                ar_load    = 1'b1;
                w_next     = S_T3;
            end
            S_T3: begin
                sc_outdata = 3'd3;
                w_next     = S_T0;
                if (r_op == 3'b111 && !r_i) begin
                    if (ir_outdata[9]) begin
                        alu_code = 4'b1001;
                        ac_load  = 1'b1;
                    end else if (ir_outdata[8]) begin
                        alu_code = 4'b1010;
                        e_load   = 1'b1;
                    end else if (ir_outdata[7]) begin
                        alu_code = 4'b1011;
                        ac_load  = 1'b1;
                        e_load   = 1'b1;
                    end else if (ir_outdata[6]) begin
                        alu_code = 4'b1100;
                        ac_load  = 1'b1;
                        e_load   = 1'b1;
                    end else if (ir_outdata[0]) begin
                        w_next = S_HALT;
                    end
                end else if (r_op == 3'b111) begin
                    if (ir_outdata[11]) begin
                        alu_code  = 4'b1101;
                        ac_load   = 1'b1;
                        fgi_clear = 1'b1;
                    end
                end else if (w_memref) begin
                    if (r_i) begin
                        mem_read = 1'b1;
                        if (mem_ack) begin
                            ar_load = 1'b1;
                            w_next  = S_T4;
                        end else begin
                            w_next = S_T3;
                        end
                    end else begin
                        w_next = S_T4;
                    end
                end
            end
            S_T4: begin
                sc_outdata = 3'd4;
                mem_read   = 1'b1;
                if (mem_ack) begin
                    dr_load = 1'b1;
                    w_next  = S_T5;
                end
            end
            S_T5: begin
                sc_outdata = 3'd5;
                ac_load    = 1'b1;
                w_next     = S_T0;
                case (r_op)
                    3'b000:  alu_code = 4'b0001;
                    3'b001: begin
                        alu_code = 4'b0010;
                        e_load   = 1'b1;
                    end
                    default: alu_code = 4'b0011;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register plus I/opcode capture during T2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_i     <= 1'b0;
            r_op    <= 3'b000;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_i  <= ir_outdata[15];
                r_op <= ir_outdata[14:12];
            end
        end
    end

endmodule
